// File: rtl/mbe_r8_iter_ctrl.sv
// mbe_r8_iter_ctrl
// Sequencer for a folded radix-8 Modified Booth mantissa multiplier. One Booth
// encode/select slice is reused for every multiplier group: after an operand
// pair is accepted, the hard multiple 3A is formed once, then one signed
// partial product d_i * A * 8^i is added per cycle for groups 0..NBLOCK_BE-1.
// The exact unsigned product is presented through a valid/ready handshake.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   flush             synchronous abort back to IDLE (wins over an accept)
//   in_valid/in_ready operand handshake; op_a, op_b unsigned mantissas,
//                     sign_a, sign_b operand signs
//   out_valid/out_ready  result handshake; product = op_a*op_b,
//                     res_sign = sign_a ^ sign_b
//   busy              high whenever not IDLE
//   grp_idx           current Booth group (debug)
//   dbg_digit         signed Booth digit of current group, zero outside ACCUM
module mbe_r8_iter_ctrl #(
  parameter int NBIT_MANTISSA = 23,
  parameter int NBLOCK_BE     = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NBIT_MANTISSA:0]     op_a,
  input  logic [NBIT_MANTISSA:0]     op_b,
  input  logic                       sign_a,
  input  logic                       sign_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*NBIT_MANTISSA+1:0] product,
  output logic                       res_sign,
  output logic                       busy,
  output logic [3:0]                 grp_idx,
  output logic [3:0]                 dbg_digit
);

  localparam int NOP  = NBIT_MANTISSA + 1;
  // Partial sums reach magnitude A*2^(3i+3); 2*NOP+3 bits hold them signed.
  localparam int NACC = 2 * NOP + 3;
  localparam logic [3:0] LAST_GRP = 4'(NBLOCK_BE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE3X = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [NOP-1:0]    a_r;
  logic [NOP-1:0]    b_r;
  logic              sa_r;
  logic              sb_r;
  logic [NOP+1:0]    a3_r;
  logic [NACC-1:0]   acc_r;
  logic [3:0]        grp_r;
  logic [2*NOP-1:0]  product_r;
  logic              res_sign_r;

  logic              accept_s;
  logic [NOP+3:0]    bx_s;
  logic [5:0]        shamt_s;
  logic [3:0]        win_s;
  logic [3:0]        digit_s;
  logic [3:0]        mag_s;
  logic [NOP+1:0]    sel_s;
  logic [NACC-1:0]   ext_s;
  logic [NACC-1:0]   pp_s;
  logic [NACC-1:0]   acc_sum_s;

  // Radix-8 Booth recoding of {b[3i+2], b[3i+1], b[3i], b[3i-1]} into a
  // two's-complement digit in -4..+4.
  function automatic logic [3:0] booth_digit(input logic [3:0] bits);
    logic [3:0] d;
    case (bits)
      4'b0000: d = 4'h0;
      4'b0001: d = 4'h1;
      4'b0010: d = 4'h1;
      4'b0011: d = 4'h2;
      4'b0100: d = 4'h2;
      4'b0101: d = 4'h3;
      4'b0110: d = 4'h3;
      4'b0111: d = 4'h4;
      4'b1000: d = 4'hC;
      4'b1001: d = 4'hD;
      4'b1010: d = 4'hD;
      4'b1011: d = 4'hE;
      4'b1100: d = 4'hE;
      4'b1101: d = 4'hF;
      4'b1110: d = 4'hF;
      4'b1111: d = 4'h0;
      default: d = 4'h0;
    endcase
    return d;
  endfunction

  assign in_ready  = (state_r == IDLE) | ((state_r == DONE) & out_ready);
  assign accept_s  = in_valid & in_ready & ~flush;
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign grp_idx   = grp_r;
  assign product   = product_r;
  assign res_sign  = res_sign_r;

  // b with the implicit b[-1]=0 below and zero padding above, so group 8
  // sees {0,0,0,b[23]} and is never negative.
  assign bx_s    = {3'b000, b_r, 1'b0};
  assign shamt_s = {1'b0, grp_r, 1'b0} + {2'b00, grp_r};
  assign win_s   = bx_s[shamt_s +: 4];
  assign digit_s = booth_digit(win_s);

  // Digit magnitude and partial-product selection (3A comes from a3_r).
  always_comb begin
    mag_s = digit_s[3] ? (4'd0 - digit_s) : digit_s;
    case (mag_s)
      4'd1:    sel_s = {2'b00, a_r};
      4'd2:    sel_s = {1'b0, a_r, 1'b0};
      4'd3:    sel_s = a3_r;
      4'd4:    sel_s = {a_r, 2'b00};
      default: sel_s = {(NOP+2){1'b0}};
    endcase
    ext_s = {{(NACC-NOP-2){1'b0}}, sel_s};
    // Negative digit: inverted partial product plus one.
    if (digit_s[3]) begin
      pp_s = ~ext_s + {{(NACC-1){1'b0}}, 1'b1};
    end else begin
      pp_s = ext_s;
    end
    acc_sum_s = acc_r + (pp_s << shamt_s);
  end

  // Debug digit is only meaningful while accumulating.
  always_comb begin
    if (state_r == ACCUM) begin
      dbg_digit = digit_s;
    end else begin
      dbg_digit = 4'h0;
    end
  end

  // Next-state logic; flush forces IDLE from any state.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) state_nxt_s = PRE3X;
          else          state_nxt_s = IDLE;
        end
        PRE3X: state_nxt_s = ACCUM;
        ACCUM: begin
          if (grp_r == LAST_GRP) state_nxt_s = DONE;
          else                   state_nxt_s = ACCUM;
        end
        DONE: begin
          if (out_ready && in_valid)  state_nxt_s = PRE3X;
          else if (out_ready)         state_nxt_s = IDLE;
          else                        state_nxt_s = DONE;
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Operand capture, 3A precompute, accumulation and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r        <= {NOP{1'b0}};
      b_r        <= {NOP{1'b0}};
      sa_r       <= 1'b0;
      sb_r       <= 1'b0;
      a3_r       <= {(NOP+2){1'b0}};
      acc_r      <= {NACC{1'b0}};
      grp_r      <= 4'd0;
      product_r  <= {(2*NOP){1'b0}};
      res_sign_r <= 1'b0;
    end else if (flush) begin
      grp_r <= 4'd0;
    end else begin
      if (accept_s) begin
        a_r  <= op_a;
        b_r  <= op_b;
        sa_r <= sign_a;
        sb_r <= sign_b;
      end
      case (state_r)
        PRE3X: begin
          a3_r  <= {2'b00, a_r} + {1'b0, a_r, 1'b0};
          acc_r <= {NACC{1'b0}};
          grp_r <= 4'd0;
        end
        ACCUM: begin
          acc_r <= acc_sum_s;
          if (grp_r == LAST_GRP) begin
            product_r  <= acc_sum_s[2*NOP-1:0];
            res_sign_r <= sa_r ^ sb_r;
            grp_r      <= 4'd0;
          end else begin
            grp_r <= grp_r + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbe_r8_iter_ctrl.sv
module tb_mbe_r8_iter_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] op_a;
  logic [23:0] op_b;
  logic        sign_a;
  logic        sign_b;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] product;
  logic        res_sign;
  logic        busy;
  logic [3:0]  grp_idx;
  logic [3:0]  dbg_digit;

  int checks = 0;
  int errors = 0;

  // Observations filled by launch()
  logic [47:0] obs_prod;
  logic        obs_sign;
  int          obs_lat;
  int          obs_dig[9];

  mbe_r8_iter_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sign_a(sign_a), .sign_b(sign_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .res_sign(res_sign), .busy(busy),
    .grp_idx(grp_idx), .dbg_digit(dbg_digit)
  );

  always #5 clk = ~clk;

  // Reference: exact product
  function automatic logic [47:0] ref_prod(input logic [23:0] a, input logic [23:0] b);
    return {24'd0, a} * {24'd0, b};
  endfunction

  // Reference: radix-8 Booth digit of group i from the bit formula
  function automatic int ref_digit(input logic [23:0] b, input int i);
    int bit_v[4];
    for (int k = 0; k < 4; k++) begin
      int pos;
      pos = 3 * i - 1 + k;
      if (pos >= 0 && pos < 24) bit_v[k] = int'((b >> pos) & 24'd1);
      else                      bit_v[k] = 0;
    end
    return -4 * bit_v[3] + 2 * bit_v[2] + bit_v[1] + bit_v[0];
  endfunction

  // Offer an operand pair, wait for the result, record latency/digits/result.
  // out_ready is held high for the accept, then set to rdy.
  task automatic launch(input logic [23:0] a, input logic [23:0] b,
                        input logic sa, input logic sb, input logic rdy);
    int n;
    op_a = a; op_b = b; sign_a = sa; sign_b = sb;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) obs_dig[i] = 99;
    #1;
    n = 0;
    while (!in_ready && n < 30) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = rdy;
    obs_lat = 1;
    while (!out_valid && obs_lat < 40) begin
      if (busy && grp_idx < 4'd9) obs_dig[grp_idx] = int'($signed(dbg_digit));
      @(posedge clk); #1; obs_lat++;
    end
    obs_prod = product;
    obs_sign = res_sign;
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 48'd0 ||
        res_sign !== 1'b0 || grp_idx !== 4'd0 || dbg_digit !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b product=%h sign=%b grp=%0d dig=%h required 1 0 0 0 0 0 0",
               in_ready, out_valid, busy, product, res_sign, grp_idx, dbg_digit);
    end
  endtask

  task automatic test_basic();
    launch(24'h800000, 24'h800000, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_lat !== 11) begin
      errors++; $display("FAIL latency: got %0d required 11", obs_lat);
    end
    checks++;
    if (obs_prod !== 48'h400000000000) begin
      errors++; $display("FAIL prod_hidden: got %h required 400000000000", obs_prod);
    end
    launch(24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0, 1'b1);
    checks++;
    if (obs_prod !== 48'hFFFFFE000001 || obs_sign !== 1'b1) begin
      errors++; $display("FAIL prod_max: got %h sign %b required fffffe000001 sign 1", obs_prod, obs_sign);
    end
    checks++;
    if (dbg_digit !== 4'd0) begin
      errors++; $display("FAIL dig_done: got %h required 0", dbg_digit);
    end
  endtask

  task automatic test_3x_digits();
    launch(24'h123456, 24'hB6DB6D, 1'b0, 1'b1, 1'b1);
    checks++;
    if (obs_prod !== ref_prod(24'h123456, 24'hB6DB6D) || obs_sign !== 1'b1) begin
      errors++; $display("FAIL prod_3x: got %h required %h", obs_prod, ref_prod(24'h123456, 24'hB6DB6D));
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs_dig[i] !== ref_digit(24'hB6DB6D, i)) begin
        errors++; $display("FAIL digit_%0d: got %0d required %0d", i, obs_dig[i], ref_digit(24'hB6DB6D, i));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [47:0] exp1;
    int n;
    exp1 = ref_prod(24'hABCDEF, 24'h13579B);
    launch(24'hABCDEF, 24'h13579B, 1'b1, 1'b1, 1'b0);
    // Offer the next pair while the result is stalled
    op_a = 24'h00F00F; op_b = 24'h777777; sign_a = 1'b0; sign_b = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || product !== exp1 || res_sign !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: valid=%b prod=%h sign=%b in_ready=%b required 1 %h 0 0",
                 c, out_valid, product, res_sign, in_ready, exp1);
      end
    end
    out_ready = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL ready_release: got %b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || grp_idx !== 4'd0 || dbg_digit !== 4'd0) begin
      errors++; $display("FAIL b2b_pre3x: busy=%b valid=%b grp=%0d required 1 0 0", busy, out_valid, grp_idx);
    end
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n !== 11 || product !== ref_prod(24'h00F00F, 24'h777777) || res_sign !== 1'b1) begin
      errors++; $display("FAIL b2b_result: lat=%0d prod=%h sign=%b required 11 %h 1",
                         n, product, res_sign, ref_prod(24'h00F00F, 24'h777777));
    end
  endtask

  task automatic test_flush();
    int n;
    bit seen;
    op_a = 24'h345678; op_b = 24'h9ABCDE; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!(busy && grp_idx == 4'd4) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (grp_idx !== 4'd4) begin
      errors++; $display("FAIL flush_reach_grp4: got %0d required 4", grp_idx);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || grp_idx !== 4'd0) begin
      errors++; $display("FAIL flush_idle: busy=%b valid=%b grp=%0d required 0 0 0", busy, out_valid, grp_idx);
    end
    // flush wins over a simultaneous accept in IDLE
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (out_valid || busy) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL flush_no_valid: activity seen=%b required 0", seen);
    end
    launch(24'd3, 24'd5, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_prod !== 48'd15 || obs_lat !== 11) begin
      errors++; $display("FAIL after_flush: prod=%0d lat=%0d required 15 11", obs_prod, obs_lat);
    end
  endtask

  task automatic test_async_reset();
    int n;
    op_a = 24'h111111; op_b = 24'h222222; sign_a = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!(busy && grp_idx == 4'd2) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 48'd0 ||
        res_sign !== 1'b0 || grp_idx !== 4'd0 || dbg_digit !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: in_ready=%b valid=%b busy=%b prod=%h sign=%b grp=%0d dig=%h required reset values",
               in_ready, out_valid, busy, product, res_sign, grp_idx, dbg_digit);
    end
    #2;
    rst = 1'b0;
    sign_a = 1'b0;
  endtask

  task automatic test_random();
    logic [23:0] a, b;
    logic        sa, sb, rdy;
    logic [47:0] exp_p;
    int          sel;
    bit          dig_ok;
    for (int t = 0; t < 2500; t++) begin
      sel = $urandom_range(0, 15);
      a = 24'($urandom);
      b = 24'($urandom);
      if (sel == 0) a = 24'd0;
      if (sel == 1) b = 24'd0;
      if (sel == 2) a = 24'hFFFFFF;
      if (sel == 3) b = 24'hFFFFFF;
      sa = 1'($urandom); sb = 1'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      exp_p = ref_prod(a, b);
      launch(a, b, sa, sb, rdy);
      checks++;
      if (obs_lat !== 11 || obs_prod !== exp_p || obs_sign !== (sa ^ sb)) begin
        errors++;
        $display("FAIL rand_%0d: a=%h b=%h lat=%0d prod=%h sign=%b required 11 %h %b",
                 t, a, b, obs_lat, obs_prod, obs_sign, exp_p, sa ^ sb);
      end
      dig_ok = 1'b1;
      for (int i = 0; i < 9; i++) if (obs_dig[i] != ref_digit(b, i)) dig_ok = 1'b0;
      checks++;
      if (!dig_ok) begin
        errors++; $display("FAIL rand_digits_%0d: b=%h digit sequence differs from model", t, b);
      end
      if (!rdy) begin
        for (int c = 0; c < int'($urandom_range(1, 3)); c++) begin
          @(posedge clk); #1;
          checks++;
          if (out_valid !== 1'b1 || product !== exp_p || in_ready !== 1'b0) begin
            errors++; $display("FAIL rand_hold_%0d: valid=%b prod=%h in_ready=%b required 1 %h 0",
                               t, out_valid, product, in_ready, exp_p);
          end
        end
        out_ready = 1'b1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_a = 24'd0; op_b = 24'd0; sign_a = 1'b0; sign_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_3x_digits();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
